logic_unit_seq: RTL and testbench

- WIDTH-bit registered successor of the 1-bit logic unit; the original had AND/OR/XOR/NOT/shift-left muxed by a 3-bit opsel.
- Adds logical shift-right and rotate-left by a variable amount, executed serially at one bit per cycle by a small FSM.
- Result sits in an output register with zero/error flags; valid/ready handshakes on input and output.
- Sits between the operand-select stage and the result writeback stage of the datapath.

---
 rtl/logic_unit_seq.sv | 125 ++++++++++++
 tb/tb_logic_unit_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Registered WIDTH-bit logic unit: single-cycle bitwise ops plus serial
// (one bit per cycle) SHL/SHR/ROL, valid/ready on both sides, zero/err flags.
module logic_unit_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opsel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             err,
    output logic             busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic [1:0]       kind;

    logic [SHW-1:0]   amt;
    logic             is_shift;
    logic             accept;
    logic             start_shift;
    logic             last_step;
    logic [WIDTH-1:0] imm_res;
    logic             imm_err;
    logic [WIDTH-1:0] work_next;

    // One serial step: kind is opsel[1:0] of the shift op (00 SHL, 01 SHR, 10 ROL).
    function automatic logic [WIDTH-1:0] step1(input logic [1:0] k, input logic [WIDTH-1:0] w);
        case (k)
            2'b00:   step1 = w << 1;
            2'b01:   step1 = w >> 1;
            default: step1 = {w[WIDTH-2:0], w[WIDTH-1]};
        endcase
    endfunction

    assign amt         = b[SHW-1:0];
    assign is_shift    = opsel[2] && (opsel[1:0] != 2'b11);
    assign in_ready    = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign start_shift = accept && is_shift && (amt != '0);
    assign last_step   = (cnt == SHW'(1));
    assign busy        = (state == SHIFT);
    assign work_next   = step1(kind, work);

    // A shift by zero falls through here and returns a unchanged.
    always_comb begin
        imm_res = '0;
        imm_err = 1'b0;
        case (opsel)
            3'b000:  imm_res = a & b;
            3'b001:  imm_res = a | b;
            3'b010:  imm_res = a ^ b;
            3'b011:  imm_res = ~a;
            3'b100,
            3'b101,
            3'b110:  imm_res = a;
            default: imm_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_shift) state_next = SHIFT;
            SHIFT:   if (last_step)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
            work      <= '0;
            cnt       <= '0;
            kind      <= '0;
        end else if (state == IDLE) begin
            if (start_shift) begin
                work      <= a;
                cnt       <= amt;
                kind      <= opsel[1:0];
                out_valid <= 1'b0;
            end else if (accept) begin
                out       <= imm_res;
                zero      <= (imm_res == '0);
                err       <= imm_err;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end else begin
            work <= work_next;
            cnt  <= cnt - SHW'(1);
            if (last_step) begin
                out       <= work_next;
                zero      <= (work_next == '0);
                err       <= 1'b0;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed self-checking bench for logic_unit_seq at WIDTH=8.
module tb_logic_unit_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opsel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       zero;
    logic       err;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;

    logic_unit_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opsel(opsel), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vop);
        a        = va;
        b        = vb;
        opsel    = vop;
        in_valid = 1'b1;
    endtask

    // Accept a shift by k>0 and follow it through k busy cycles to the result.
    task automatic run_shift(input string tag, input logic [7:0] va, input logic [7:0] vb,
                             input logic [2:0] vop, input int k, input logic [7:0] exp);
        drive(va, vb, vop);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'(1));
            check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
            check({tag, "_vld_early"}, 32'(out_valid), 32'(0));
            tick();
        end
        check({tag, "_vld"}, 32'(out_valid), 32'(1));
        check({tag, "_out"}, 32'(out), 32'(exp));
        check({tag, "_err"}, 32'(err), 32'(0));
        check({tag, "_busy_done"}, 32'(busy), 32'(0));
        tick();
        check({tag, "_drained"}, 32'(out_valid), 32'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        opsel     = '0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out", 32'(out), 32'(0));
        check("rst_zero", 32'(zero), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'(1));

        // AND, then back-to-back OR and XOR
        drive(8'hCC, 8'hAA, 3'b000);
        tick();
        check("and_vld", 32'(out_valid), 32'(1));
        check("and_out", 32'(out), 32'h88);
        check("and_zero", 32'(zero), 32'(0));
        check("and_err", 32'(err), 32'(0));
        drive(8'hF0, 8'h0F, 3'b001);
        check("b2b_in_ready1", 32'(in_ready), 32'(1));
        tick();
        check("or_out", 32'(out), 32'hFF);
        check("or_vld", 32'(out_valid), 32'(1));
        drive(8'h5A, 8'h5A, 3'b010);
        check("b2b_in_ready2", 32'(in_ready), 32'(1));
        tick();
        check("xor_out", 32'(out), 32'h00);
        check("xor_zero", 32'(zero), 32'(1));
        check("b2b_in_ready3", 32'(in_ready), 32'(1));
        drive(8'h3C, 8'h00, 3'b011);
        tick();
        check("not_out", 32'(out), 32'hC3);
        in_valid = 1'b0;
        tick();
        check("drain_vld", 32'(out_valid), 32'(0));

        // Serial shifts
        run_shift("shl3", 8'h81, 8'h03, 3'b100, 3, 8'h08);
        run_shift("rol1", 8'h81, 8'h01, 3'b110, 1, 8'h03);
        run_shift("shr7", 8'h80, 8'h07, 3'b101, 7, 8'h01);
        run_shift("rol4", 8'h96, 8'hF4, 3'b110, 4, 8'h69);

        // Amount 0 (b[2:0]==0): pass-through with latency 1
        drive(8'h5A, 8'h08, 3'b100);
        tick();
        in_valid = 1'b0;
        check("shl0_busy", 32'(busy), 32'(0));
        check("shl0_vld", 32'(out_valid), 32'(1));
        check("shl0_out", 32'(out), 32'h5A);
        tick();

        // Reserved opsel, then err clears
        drive(8'hFF, 8'hFF, 3'b111);
        tick();
        check("rsv_out", 32'(out), 32'(0));
        check("rsv_zero", 32'(zero), 32'(1));
        check("rsv_err", 32'(err), 32'(1));
        drive(8'hFF, 8'h0F, 3'b000);
        tick();
        check("clr_out", 32'(out), 32'h0F);
        check("clr_err", 32'(err), 32'(0));
        check("clr_zero", 32'(zero), 32'(0));
        in_valid = 1'b0;
        tick();

        // Backpressure: result held, then consume and accept on same edge
        out_ready = 1'b0;
        drive(8'h3C, 8'hFF, 3'b000);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_vld", 32'(out_valid), 32'(1));
            check("bp_out", 32'(out), 32'h3C);
            tick();
        end
        drive(8'h12, 8'h34, 3'b010);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        check("bp_new_vld", 32'(out_valid), 32'(1));
        check("bp_new_out", 32'(out), 32'h26);
        tick();
        check("bp_drained", 32'(out_valid), 32'(0));

        // Reset during SHL by 6 after two shift cycles
        drive(8'hFF, 8'h06, 3'b100);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(out_valid), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_out", 32'(out), 32'(0));
        check("mid_rst_ready", 32'(in_ready), 32'(0));
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_vld", 32'(out_valid), 32'(0));
        drive(8'hF0, 8'h3C, 3'b000);
        tick();
        in_valid = 1'b0;
        check("post_and_vld", 32'(out_valid), 32'(1));
        check("post_and_out", 32'(out), 32'h30);
        check("post_and_err", 32'(err), 32'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
